// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared constants and state type for the WS2812 serializer
package ws2812_pkg;

    localparam int BITS_PER_LED = 24;

    // 50 MHz defaults
    localparam int DEF_T0H_CYC  = 18;
    localparam int DEF_T1H_CYC  = 35;
    localparam int DEF_TBIT_CYC = 63;
    localparam int DEF_TRST_CYC = 2600;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_serializer_if.sv
// rtl/ws2812_serializer_if.sv - frame request and strip output bundle
import ws2812_pkg::*;

interface ws2812_serializer_if #(
    parameter int NUM_LEDS = 5
);
    logic [BITS_PER_LED*NUM_LEDS-1:0] grb_data;
    logic                             start;
    logic                             busy;
    logic                             done;
    logic                             dout;

    modport master (output grb_data, start, input busy, done, dout);
    modport slave  (input grb_data, start, output busy, done, dout);
endinterface

// File: rtl/ws2812_bit_timer.sv
// rtl/ws2812_bit_timer.sv - one NRZ bit period: registered high pulse plus end strobe
module ws2812_bit_timer #(
    parameter int T0H_CYC  = 18,
    parameter int T1H_CYC  = 35,
    parameter int TBIT_CYC = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic go_i,
    input  logic bit_i,
    output logic high_o,
    output logic bit_end_o
);
    localparam int CNT_W = (TBIT_CYC > 1) ? $clog2(TBIT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             act_q, act_d;
    logic             high_q, high_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            bit_q  <= 1'b0;
            act_q  <= 1'b0;
            high_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            act_q  <= act_d;
            high_q <= high_d;
        end
    end

    assign bit_end_o = act_q && (cnt_q == CNT_W'(TBIT_CYC - 1));

    // high_d is derived from next-state values so the pin flop lines up with the counter
    always_comb begin
        cnt_d = cnt_q;
        bit_d = bit_q;
        act_d = act_q;
        if (go_i) begin
            cnt_d = '0;
            bit_d = bit_i;
            act_d = 1'b1;
        end else if (act_q) begin
            if (bit_end_o) begin
                act_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        high_d = act_d && (cnt_d < (bit_d ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC)));
    end

    assign high_o = high_q;

endmodule

// File: rtl/ws2812_serializer.sv
// rtl/ws2812_serializer.sv - GRB frame to WS2812 single-wire NRZ waveform with latch gap
import ws2812_pkg::*;

module ws2812_serializer #(
    parameter int NUM_LEDS = 5,
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int TBIT_CYC = DEF_TBIT_CYC,
    parameter int TRST_CYC = DEF_TRST_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    ws2812_serializer_if.slave   bus
);
    localparam int FRAME_W = BITS_PER_LED * NUM_LEDS;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int CYC_W   = $clog2(max_int(TBIT_CYC, TRST_CYC));

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CYC_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               go;
    logic               bit_val;
    logic               bit_end;
    logic               high;

    ws2812_bit_timer #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .go_i      (go),
        .bit_i     (bit_val),
        .high_o    (high),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            lat_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The bit handed to the timer is always the MSB of the next shift-register value
    assign bit_val = sr_d[FRAME_W-1];

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        lat_cnt_d = lat_cnt_q;
        done_d    = 1'b0;
        go        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d      = bus.grb_data;
                    bit_cnt_d = '0;
                    go        = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (bit_end) begin
                    sr_d = sr_q << 1;
                    if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
                        lat_cnt_d = '0;
                        state_d   = LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        go        = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (lat_cnt_q == CYC_W'(TRST_CYC - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = high;

endmodule
